// File: rtl/uart_pkg.sv
// Shared state encodings and constants for the UART transmitter slice.
`ifndef UART_PKG_SV
`define UART_PKG_SV

package uart_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STATE_W   = 3;

    typedef enum logic [UART_STATE_W-1:0] {
        UART_IDLE   = 3'd0,
        UART_START  = 3'd1,
        UART_DATA   = 3'd2,
        UART_STOP   = 3'd3,
        UART_PARITY = 3'd4
    } uart_state_t;

    // Even parity: the bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

`endif

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead head data and an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sync_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    // Head is presented combinationally so a pop can load it the same cycle.
    assign rd_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_reg[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// Buffered UART transmitter: 8N1 by default, 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100000000,
    parameter int BAUD_RATE  = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          valid_i,
    input  logic [7:0]                    data_i,
    output logic                          ready_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          tx_o
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BAUD_W       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = $clog2(UART_DATA_BITS);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_baud
            $error("uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
        end
    endgenerate

    uart_state_t               state_reg;
    logic                      tx_reg;
    logic [BAUD_W-1:0]         baud_cnt_reg;
    logic [IDX_W-1:0]          bit_idx_reg;
    logic [UART_DATA_BITS-1:0] shift_reg;
`ifdef UART_TX_PARITY_EN
    logic                      parity_reg;
`endif

    logic                      bit_end;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [7:0]                fifo_rd_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push    (valid_i),
        .wr_data (data_i),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign bit_end  = (baud_cnt_reg == BAUD_W'(CLKS_PER_BIT - 1));
    // Popping at the end of STOP chains frames with no idle gap.
    assign fifo_pop = !fifo_empty &&
                      ((state_reg == UART_IDLE) || (state_reg == UART_STOP && bit_end));

    assign ready_o = !fifo_full;
    assign busy_o  = (state_reg != UART_IDLE) || (fifo_count != '0);
    assign count_o = fifo_count;
    assign tx_o    = tx_reg;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_reg    <= UART_IDLE;
            tx_reg       <= 1'b1;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            shift_reg    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            if (state_reg != UART_IDLE) begin
                baud_cnt_reg <= bit_end ? '0 : baud_cnt_reg + 1'b1;
            end

            case (state_reg)
                UART_IDLE: begin
                    baud_cnt_reg <= '0;
                    if (fifo_pop) begin
                        shift_reg <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                        parity_reg <= even_parity(fifo_rd_data);
`endif
                        state_reg <= UART_START;
                        tx_reg    <= 1'b0;
                    end else begin
                        tx_reg <= 1'b1;
                    end
                end

                UART_START: begin
                    if (bit_end) begin
                        state_reg   <= UART_DATA;
                        bit_idx_reg <= '0;
                        tx_reg      <= shift_reg[0];
                    end
                end

                UART_DATA: begin
                    if (bit_end) begin
                        shift_reg   <= shift_reg >> 1;
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == IDX_W'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            state_reg <= UART_PARITY;
                            tx_reg    <= parity_reg;
`else
                            state_reg <= UART_STOP;
                            tx_reg    <= 1'b1;
`endif
                        end else begin
                            tx_reg <= shift_reg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                UART_PARITY: begin
                    if (bit_end) begin
                        state_reg <= UART_STOP;
                        tx_reg    <= 1'b1;
                    end
                end
`endif

                UART_STOP: begin
                    if (bit_end) begin
                        if (fifo_pop) begin
                            shift_reg <= fifo_rd_data;
`ifdef UART_TX_PARITY_EN
                            parity_reg <= even_parity(fifo_rd_data);
`endif
                            state_reg <= UART_START;
                            tx_reg    <= 1'b0;
                        end else begin
                            state_reg <= UART_IDLE;
                            tx_reg    <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= UART_IDLE;
                    tx_reg    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at 16 clocks per bit; covers 8E1 when UART_TX_PARITY_EN is defined.
module tb_uart_tx;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       reset_i = 1'b0;
    logic       valid_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       ready_o;
    logic       busy_o;
    logic [2:0] count_o;
    logic       tx_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    uart_tx #(
        .CLK_FREQ   (16),
        .BAUD_RATE  (1),
        .FIFO_DEPTH (4)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .busy_o  (busy_o),
        .count_o (count_o),
        .tx_o    (tx_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Line bits LSB first: start, data[0..7], (parity), stop.
    function automatic logic [10:0] exp_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b0, 1'b1, b, 1'b0};
`endif
    endfunction

    task automatic wait_start(input string tag);
        int n;
        n = 0;
        while (tx_o !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_start_seen"}, tx_o, 1'b0);
    endtask

    // Called on the first negedge of a start bit; returns on the last negedge of the frame.
    task automatic rx_frame(output logic [10:0] bits);
        bits = '0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c % CPB == CPB / 2) bits[c / CPB] = tx_o;
            if (c < FRAME_CYC - 1) @(negedge clk);
        end
        $display("frame: line bits 0x%03h -> byte 0x%02h", bits, bits[8:1]);
    endtask

    logic [10:0] bits;
    int          stall [7];

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", tx_o, 1'b1);
        check("rst_ready", ready_o, 1'b1);
        check("rst_busy", busy_o, 1'b0);
        check("rst_count", count_o, 3'd0);
        reset_i = 1'b1;
        @(negedge clk);

        // Single byte 0xA5
        valid_i = 1'b1; data_i = 8'hA5;
        @(negedge clk);
        valid_i = 1'b0;
        $display("push 0xa5");
        check("t1_count_after_push", count_o, 3'd1);
        check("t1_tx_idle_after_push", tx_o, 1'b1);
        @(negedge clk);
        check("t1_tx_fall", tx_o, 1'b0);
        check("t1_count_after_pop", count_o, 3'd0);
        rx_frame(bits);
`ifdef UART_TX_PARITY_EN
        check("t1_bits", bits, 11'b1_0_10100101_0);
`else
        check("t1_bits", bits, 11'b0_1_10100101_0);
`endif
        check("t1_busy_last_cycle", busy_o, 1'b1);
        @(negedge clk);
        check("t1_busy_end", busy_o, 1'b0);
        check("t1_tx_end", tx_o, 1'b1);

        // Back-to-back 0x00, 0xFF: second push coincides with the first pop
        repeat (3) @(negedge clk);
        valid_i = 1'b1; data_i = 8'h00;
        @(negedge clk);
        check("t2_count_a", count_o, 3'd1);
        data_i = 8'hFF;
        @(negedge clk);
        valid_i = 1'b0;
        $display("push 0x00, 0xff");
        check("t2_count_pushpop", count_o, 3'd1);
        check("t2_tx_fall", tx_o, 1'b0);
        rx_frame(bits);
        check("t2_bits0", bits, exp_frame(8'h00));
        @(negedge clk);
        check("t2_no_gap", tx_o, 1'b0);
        check("t2_count_b", count_o, 3'd0);
        rx_frame(bits);
        check("t2_bits1", bits, exp_frame(8'hFF));
        @(negedge clk);
        check("t2_busy_end", busy_o, 1'b0);

        // Fill past full with valid_i held high; bytes 6 and 7 stall
        repeat (3) @(negedge clk);
        fork
            begin
                for (int b = 0; b < 7; b++) begin
                    valid_i = 1'b1;
                    data_i  = 8'(b + 1);
                    stall[b] = 0;
                    while (ready_o !== 1'b1 && stall[b] < 1000) begin
                        @(negedge clk);
                        stall[b]++;
                    end
                    if (b >= 5) check($sformatf("t4_count_at_boundary_%0d", b), count_o, 3'd3);
                    @(negedge clk);
                    $display("push 0x%02h after %0d stall cycles", 8'(b + 1), stall[b]);
                    if (b == 4 || b == 5) begin
                        check($sformatf("t3_full_count_%0d", b), count_o, 3'd4);
                        check($sformatf("t3_full_ready_%0d", b), ready_o, 1'b0);
                    end
                end
                valid_i = 1'b0;
            end
            begin
                for (int k = 0; k < 7; k++) begin
                    if (k == 0) wait_start("t3");
                    else check($sformatf("t3_no_gap_%0d", k), tx_o, 1'b0);
                    rx_frame(bits);
                    check($sformatf("t3_byte_%0d", k + 1), bits, exp_frame(8'(k + 1)));
                    @(negedge clk);
                end
            end
        join
        for (int b = 0; b < 5; b++) check($sformatf("t3_stall_%0d", b + 1), stall[b], 0);
        check("t3_stall_6", stall[5], FRAME_CYC - 3);
        check("t4_stall_7", stall[6], FRAME_CYC - 1);
        check("t3_busy_end", busy_o, 1'b0);
        check("t3_count_end", count_o, 3'd0);

        // Reset during DATA bit 3 of 0x3C with 0x55 still queued
        repeat (3) @(negedge clk);
        valid_i = 1'b1; data_i = 8'h3C;
        @(negedge clk);
        data_i = 8'h55;
        @(negedge clk);
        valid_i = 1'b0;
        $display("push 0x3c, 0x55");
        wait_start("t5");
        repeat (4 * CPB + CPB / 2) @(negedge clk);
        check("t5_bit3", tx_o, 1'b1);
        check("t5_count_pre", count_o, 3'd1);
        reset_i = 1'b0;
        @(negedge clk);
        $display("reset asserted mid-frame");
        check("t5_rst_tx", tx_o, 1'b1);
        check("t5_rst_count", count_o, 3'd0);
        check("t5_rst_busy", busy_o, 1'b0);
        check("t5_rst_ready", ready_o, 1'b1);
        reset_i = 1'b1;
        repeat (2) @(negedge clk);
        check("t5_idle_tx", tx_o, 1'b1);
        valid_i = 1'b1; data_i = 8'h81;
        @(negedge clk);
        valid_i = 1'b0;
        $display("push 0x81");
        wait_start("t5b");
        rx_frame(bits);
        check("t5_bits", bits, exp_frame(8'h81));
        @(negedge clk);
        check("t5_busy_end", busy_o, 1'b0);

`ifdef UART_TX_PARITY_EN
        // 8E1 frames: 0x07 has odd weight, 0x03 even
        repeat (3) @(negedge clk);
        valid_i = 1'b1; data_i = 8'h07;
        @(negedge clk);
        valid_i = 1'b0;
        $display("push 0x07");
        wait_start("t6a");
        rx_frame(bits);
        check("t6_bits_07", bits, 11'b1_1_00000111_0);
        check("t6_busy_last_07", busy_o, 1'b1);
        @(negedge clk);
        check("t6_busy_end_07", busy_o, 1'b0);
        valid_i = 1'b1; data_i = 8'h03;
        @(negedge clk);
        valid_i = 1'b0;
        $display("push 0x03");
        wait_start("t6b");
        rx_frame(bits);
        check("t6_bits_03", bits, 11'b1_0_00000011_0);
        @(negedge clk);
        check("t6_busy_end_03", busy_o, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
